division_seq: RTL and testbench
===============================

DIVISION_SEQ -- requirements
Module: division_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse; operands sampled on the same edge.
REQ-005 SHALL have port Dividend  input  WIDTH  numerator.
REQ-006 SHALL have port Divisor  input  WIDTH  denominator.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port Quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port Reminder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  set with done when Divisor was zero.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; the only transitions are IDLE->CALC, IDLE->DONE, CALC->DONE, DONE->IDLE, DONE->CALC, DONE->DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored with no effect on operation or outputs.
REQ-014 On accepted start with Divisor!=0: latch operands, clear partial remainder and iteration counter, enter CALC.
REQ-015 SHALL use restoring shift-subtract, one quotient bit per clock, MSB first, WIDTH iterations, with a WIDTH+1-bit partial remainder to avoid overflow.
REQ-016 SHALL enter DONE on the WIDTH-th edge after the accepting edge, loading Quotient/Reminder on that edge.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; busy SHALL be high exactly while in CALC.
REQ-018 On accepted start with Divisor==0: go directly to DONE on the next edge with Quotient = all ones, Reminder = Dividend, div_by_zero=1; no CALC cycles.
REQ-019 div_by_zero SHALL be cleared on every accepted start and SHALL hold its value with the results.
REQ-020 Quotient, Reminder and div_by_zero SHALL hold their values until the next result load or reset.
REQ-021 start in DONE SHALL begin a new operation (back-to-back); otherwise DONE->IDLE.
REQ-022 Operand input changes after the accepting edge SHALL NOT affect the running result.

Reset
REQ-023 rst high at a rising edge SHALL force IDLE, busy=0, done=0, Quotient=0, Reminder=0, div_by_zero=0, counter=0.
REQ-024 rst SHALL abort an operation mid-CALC with no done pulse; rst SHALL take priority over a simultaneous start.

Configuration
REQ-025 Macro DIVISION_SEQ_SIGNED_EN defined: operands SHALL be two's complement; magnitudes divided per REQ-015; quotient SHALL be truncated toward zero and the remainder SHALL carry the dividend's sign; latency SHALL be unchanged.
REQ-026 Under DIVISION_SEQ_SIGNED_EN, most-negative / -1 SHALL return Quotient = most-negative value and Reminder=0; divide-by-zero SHALL return Quotient = all ones and Reminder = Dividend.
REQ-027 Macro undefined: operands SHALL be treated as unsigned and no sign logic SHALL be present.

Verification
REQ-028 WIDTH=8, Dividend=133, Divisor=17, start pulse -> busy for 8 cycles, then done pulse with Quotient=7, Reminder=14, div_by_zero=0.
REQ-029 Dividend=133, Divisor=0 -> done on the next cycle with Quotient=8'hFF, Reminder=133, div_by_zero=1, busy never high.
REQ-030 Dividend=255, Divisor=1, start, then a second start 3 cycles later with 10/3 -> second start ignored; result Quotient=255, Reminder=0.
REQ-031 Start in the DONE cycle with 10/3 -> new CALC without an IDLE cycle; done 8 cycles later with Quotient=3, Reminder=1.
REQ-032 rst asserted 4 cycles into CALC -> all outputs 0, no done pulse, next start of 100/7 gives Quotient=14, Reminder=2.
REQ-033 DIVISION_SEQ_SIGNED_EN, -7/2 -> Quotient=8'hFD, Reminder=8'hFF; -128/-1 -> Quotient=8'h80, Reminder=0.

Source files
------------

// File: rtl/division_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, WIDTH iterations.
// Define DIVISION_SEQ_SIGNED_EN for two's-complement operands (truncating quotient, remainder takes dividend sign).
module division_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Reminder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder, always < divisor
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
`ifdef DIVISION_SEQ_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic             accept;
  logic [WIDTH:0]   trial;            // shifted remainder needs WIDTH+1 bits before the subtract
  logic [WIDTH-1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept = start && (state_q != CALC);
  assign trial  = {prem_q, dvd_q[WIDTH-1]};
  assign qbit   = (trial >= {1'b0, dsr_q});
  assign diff   = trial[WIDTH-1:0] - dsr_q;

`ifdef DIVISION_SEQ_SIGNED_EN
  assign a_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign b_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
`else
  assign a_mag = Dividend;
  assign b_mag = Divisor;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through this block can infer a latch.
    state_d = state_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef DIVISION_SEQ_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    if (accept) begin
      dbz_d = 1'b0;
      if (Divisor == '0) begin
        state_d = DONE;
        quo_d   = '1;
        rmd_d   = Dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = CALC;
        dvd_d   = a_mag;
        dsr_d   = b_mag;
        prem_d  = '0;
        cnt_d   = '0;
`ifdef DIVISION_SEQ_SIGNED_EN
        qneg_d  = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
        rneg_d  = Dividend[WIDTH-1];
`endif
      end
    end else if (state_q == CALC) begin
      prem_d = qbit ? diff : trial[WIDTH-1:0];
      dvd_d  = {dvd_q[WIDTH-2:0], qbit};
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
`ifdef DIVISION_SEQ_SIGNED_EN
        quo_d   = qneg_q ? -dvd_d : dvd_d;
        rmd_d   = rneg_q ? -prem_d : prem_d;
`else
        quo_d   = dvd_d;
        rmd_d   = prem_d;
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIVISION_SEQ_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef DIVISION_SEQ_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign Quotient    = quo_q;
  assign Reminder    = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division_seq.sv
// Scoreboard bench for division_seq (WIDTH=8); expected results queued at start, compared at done.
module tb_division_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, reminder;

  typedef struct packed {
    logic [7:0] quo;
    logic [7:0] rmd;
    logic       dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  division_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .Dividend    (dividend),
    .Divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .Quotient    (quotient),
    .Reminder    (reminder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.quo = 8'hFF;
      e.rmd = a;
      e.dbz = 1'b1;
    end else begin
`ifdef DIVISION_SEQ_SIGNED_EN
      int sa = int'($signed(a));
      int sb = int'($signed(b));
      e.quo = 8'(sa / sb);
      e.rmd = 8'(sa % sb);
`else
      e.quo = a / b;
      e.rmd = a % b;
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drives a one-cycle start; operands are scrambled right after the accepting edge.
  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input bit push);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int  lat  = 0;
    int  nb   = 0;
    bit  seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_cycles"}, nb, exp_busy);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        last_exp = e;
        check({tag, "_quo"}, 32'(quotient), 32'(e.quo));
        check({tag, "_rmd"}, 32'(reminder), 32'(e.rmd));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
      end
    end
  endtask

  task automatic check_idle_hold(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold_quo"}, 32'(quotient), 32'(last_exp.quo));
    check({tag, "_hold_rmd"}, 32'(reminder), 32'(last_exp.rmd));
    check({tag, "_hold_dbz"}, 32'(div_by_zero), 32'(last_exp.dbz));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_quo"},  32'(quotient), 32'd0);
    check({tag, "_rmd"},  32'(reminder), 32'd0);
    check({tag, "_dbz"},  32'(div_by_zero), 32'd0);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    do_start(8'd133, 8'd17, 1'b1);
    wait_done("div133_17", 9, 8);
    check_idle_hold("div133_17");

    do_start(8'd133, 8'd0, 1'b1);
    wait_done("div133_0", 1, 0);
    check_idle_hold("div133_0");

    // Start while CALC must be ignored.
    do_start(8'd255, 8'd1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dividend = 8'd10; divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start", 6, 5);

    // Back-to-back: start raised during the DONE cycle.
    start = 1'b1; dividend = 8'd10; divisor = 8'd3;
    sb_q.push_back(model(8'd10, 8'd3));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("back2back", 9, 8);
    check_idle_hold("back2back");

    // Reset four cycles into CALC aborts without done.
    do_start(8'd200, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("abort");
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    do_start(8'd100, 8'd7, 1'b1);
    wait_done("div100_7", 9, 8);
    check_idle_hold("div100_7");

    // Reset wins over a simultaneous start.
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_zero_outputs("rst_prio");

    do_start(8'd0, 8'd5, 1'b1);
    wait_done("zero_num", 9, 8);
    do_start(8'd255, 8'd255, 1'b1);
    wait_done("max_max", 9, 8);
    do_start(8'd7, 8'd200, 1'b1);
    wait_done("small_big", 9, 8);

`ifdef DIVISION_SEQ_SIGNED_EN
    do_start(8'hF9, 8'd2, 1'b1);
    wait_done("s_m7_2", 9, 8);
    do_start(8'h80, 8'hFF, 1'b1);
    wait_done("s_m128_m1", 9, 8);
    do_start(8'd7, 8'hFE, 1'b1);
    wait_done("s_7_m2", 9, 8);
    do_start(8'h80, 8'd0, 1'b1);
    wait_done("s_m128_0", 1, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = (i == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      do_start(a, b, 1'b1);
      wait_done("rand", (b == 8'd0) ? 1 : 9, (b == 8'd0) ? 0 : 8);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
